// File: rtl/db_pkg.sv
// db_pkg: shared widths, status codes, owner ids
// and state encoding for the DB request arbiter.
package db_pkg;

  localparam int DB_KEY_SIZE  = 96;
  localparam int DB_FLAG_SIZE = 4;

  typedef enum logic [3:0] {
    SUSPECTION   = 4'd1,
    ARREST       = 4'd2,
    FILTERED     = 4'd3,
    EXPIRED      = 4'd4,
    FLAG_TIMEOUT = 4'hF
  } status_t;

  typedef enum logic {
    PORT_PKT = 1'b0,
    PORT_CTL = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/db_arb_prio.sv
// db_arb_prio: fixed priority to port 0 with a
// starvation limit that forces a port 1 grant.
module db_arb_prio
  import db_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic grant_en,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  logic [7:0] starve_q;
  logic       at_lim;

  assign at_lim = (starve_q == SMAX);
  assign gnt1   = grant_en & req1_valid
                & (at_lim | ~req0_valid);
  assign gnt0   = grant_en & req0_valid
                & ~(req1_valid & at_lim);

  // count port 0 wins while port 1 waits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!req1_valid || gnt1) begin
      starve_q <= '0;
    end else if (gnt0 && !at_lim) begin
      starve_q <= starve_q + 8'd1;
    end
  end

endmodule

// File: rtl/db_req_arbiter.sv
// db_req_arbiter: one outstanding DB operation,
// owner tagging, reply routing and reply timeout.
module db_req_arbiter
  import db_pkg::*;
#(
  parameter int KEY_SIZE   = DB_KEY_SIZE,
  parameter int FLAG_SIZE  = DB_FLAG_SIZE,
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [KEY_SIZE-1:0]  req0_key,
  input  logic [FLAG_SIZE-1:0] req0_flag,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [KEY_SIZE-1:0]  req1_key,
  input  logic [FLAG_SIZE-1:0] req1_flag,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic [FLAG_SIZE-1:0] rsp0_flag,
  output logic                 rsp1_valid,
  output logic [FLAG_SIZE-1:0] rsp1_flag,
  output logic                 db_valid,
  output logic [KEY_SIZE-1:0]  db_key,
  output logic [FLAG_SIZE-1:0] db_flag,
  input  logic                 db_ready,
  input  logic                 db_out_valid,
  input  logic [FLAG_SIZE-1:0] db_out_flag,
  output logic [15:0]          stray_cnt,
  output logic [15:0]          timeout_cnt
);

  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT - 1);
  localparam logic [FLAG_SIZE-1:0] F_TMO =
    FLAG_SIZE'(FLAG_TIMEOUT);

  state_t                 state_q;
  owner_t                 owner_q;
  logic [KEY_SIZE-1:0]    key_q;
  logic [FLAG_SIZE-1:0]   flag_q;
  logic                   dbv_q;
  logic                   r0v_q;
  logic                   r1v_q;
  logic [FLAG_SIZE-1:0]   r0f_q;
  logic [FLAG_SIZE-1:0]   r1f_q;
  logic [15:0]            timer_q;
  logic [15:0]            stray_q;
  logic [15:0]            tmo_q;

  logic                   grant_en;
  logic                   gnt0;
  logic                   gnt1;
  logic                   done;
  logic [FLAG_SIZE-1:0]   rsp_flag;

  assign grant_en = rst_n & db_ready
                  & (state_q == S_IDLE);

  db_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant_en   (grant_en),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // a real reply beats expiry in the same cycle
  assign done = (state_q == S_WAIT)
              & (db_out_valid | (timer_q == TMO_LAST));
  assign rsp_flag = db_out_valid ? db_out_flag : F_TMO;

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign db_valid    = dbv_q;
  assign db_key      = key_q;
  assign db_flag     = flag_q;
  assign rsp0_valid  = r0v_q;
  assign rsp0_flag   = r0f_q;
  assign rsp1_valid  = r1v_q;
  assign rsp1_flag   = r1f_q;
  assign stray_cnt   = stray_q;
  assign timeout_cnt = tmo_q;

  // issue/wait FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= PORT_PKT;
      key_q   <= '0;
      flag_q  <= '0;
      dbv_q   <= 1'b0;
      r0v_q   <= 1'b0;
      r1v_q   <= 1'b0;
      r0f_q   <= '0;
      r1f_q   <= '0;
      timer_q <= '0;
      stray_q <= '0;
      tmo_q   <= '0;
    end else begin
      dbv_q <= 1'b0;
      r0v_q <= 1'b0;
      r1v_q <= 1'b0;
      r0f_q <= '0;
      r1f_q <= '0;
      if (db_out_valid && state_q != S_WAIT) begin
        stray_q <= sat_inc(stray_q);
      end
      unique case (state_q)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            key_q   <= gnt1 ? req1_key : req0_key;
            flag_q  <= gnt1 ? req1_flag : req0_flag;
            owner_q <= gnt1 ? PORT_CTL : PORT_PKT;
            dbv_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= timer_q + 16'd1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + 16'd1;
          if (done) begin
            if (owner_q == PORT_CTL) begin
              r1v_q <= 1'b1;
              r1f_q <= rsp_flag;
            end else begin
              r0v_q <= 1'b1;
              r0f_q <= rsp_flag;
            end
            if (!db_out_valid) begin
              tmo_q <= sat_inc(tmo_q);
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_req_arbiter.sv
// tb_db_req_arbiter: directed stimulus, cycle model
// compared every cycle, plus literal spot checks.
module tb_db_req_arbiter;

  localparam int KS   = 96;
  localparam int FS   = 4;
  localparam int SMAX = 8;
  localparam int TMO  = 16;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic [KS-1:0] req0_key;
  logic [FS-1:0] req0_flag;
  logic          req0_ready;
  logic          req1_valid;
  logic [KS-1:0] req1_key;
  logic [FS-1:0] req1_flag;
  logic          req1_ready;
  logic          rsp0_valid;
  logic [FS-1:0] rsp0_flag;
  logic          rsp1_valid;
  logic [FS-1:0] rsp1_flag;
  logic          db_valid;
  logic [KS-1:0] db_key;
  logic [FS-1:0] db_flag;
  logic          db_ready;
  logic          db_out_valid;
  logic [FS-1:0] db_out_flag;
  logic [15:0]   stray_cnt;
  logic [15:0]   timeout_cnt;

  int errors = 0;
  int checks = 0;

  db_req_arbiter #(
    .KEY_SIZE   (KS),
    .FLAG_SIZE  (FS),
    .STARVE_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_key     (req0_key),
    .req0_flag    (req0_flag),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_key     (req1_key),
    .req1_flag    (req1_flag),
    .req1_ready   (req1_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_flag    (rsp0_flag),
    .rsp1_valid   (rsp1_valid),
    .rsp1_flag    (rsp1_flag),
    .db_valid     (db_valid),
    .db_key       (db_key),
    .db_flag      (db_flag),
    .db_ready     (db_ready),
    .db_out_valid (db_out_valid),
    .db_out_flag  (db_out_flag),
    .stray_cnt    (stray_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  // model: one operation in flight, reply or
  // timeout answered the cycle after, counters
  int          cyc    = 0;
  bit          busy   = 0;
  bit          own    = 0;
  int          iss    = -100;
  int          rsp_at = -100;
  bit          rown   = 0;
  logic [3:0]  rflag  = '0;
  logic [95:0] mkey   = '0;
  logic [3:0]  mflag  = '0;
  int          mstray = 0;
  int          mtmo   = 0;
  int          starve = 0;

  always @(negedge clk) begin
    bit g0, g1, waiting, r0, r1;
    if (!rst_n) begin
      busy   = 0;
      iss    = -100;
      rsp_at = -100;
      mkey   = '0;
      mflag  = '0;
      mstray = 0;
      mtmo   = 0;
      starve = 0;
    end else begin
      g1 = !busy && db_ready && req1_valid
        && (!req0_valid || starve == SMAX);
      g0 = !busy && db_ready && req0_valid && !g1;
      r0 = (rsp_at == cyc) && !rown;
      r1 = (rsp_at == cyc) && rown;
      chk("m_req0_ready", req0_ready, g0);
      chk("m_req1_ready", req1_ready, g1);
      chk("m_db_valid", db_valid, cyc == iss);
      chk("m_db_key", db_key, mkey);
      chk("m_db_flag", db_flag, mflag);
      chk("m_rsp0_valid", rsp0_valid, r0);
      chk("m_rsp0_flag", rsp0_flag, r0 ? rflag : 4'h0);
      chk("m_rsp1_valid", rsp1_valid, r1);
      chk("m_rsp1_flag", rsp1_flag, r1 ? rflag : 4'h0);
      chk("m_stray_cnt", stray_cnt, mstray);
      chk("m_timeout_cnt", timeout_cnt, mtmo);
      waiting = busy && (cyc > iss);
      if (db_out_valid && !waiting && mstray < 65535)
        mstray++;
      if (waiting && db_out_valid) begin
        rsp_at = cyc + 1;
        rown   = own;
        rflag  = db_out_flag;
        busy   = 0;
      end else if (waiting && cyc - iss == TMO - 1) begin
        rsp_at = cyc + 1;
        rown   = own;
        rflag  = 4'hF;
        if (mtmo < 65535) mtmo++;
        busy   = 0;
      end
      if (!req1_valid || g1) starve = 0;
      else if (g0 && starve < SMAX) starve++;
      if (g0 || g1) begin
        busy  = 1;
        own   = g1;
        iss   = cyc + 1;
        mkey  = g1 ? req1_key : req0_key;
        mflag = g1 ? req1_flag : req0_flag;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(output int who);
    int n;
    n = 0;
    who = -1;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("serve_grant_wait", 0, 1);
      return;
    end
    who = req1_ready ? 1 : 0;
    tick();
    tick();
    db_out_valid = 1'b1;
    db_out_flag  = (who == 1) ? 4'h2 : 4'h3;
    tick();
    db_out_valid = 1'b0;
    db_out_flag  = 4'h0;
  endtask

  int gseq[18];

  initial begin
    rst_n        = 1'b0;
    req0_valid   = 1'b0;
    req0_key     = '0;
    req0_flag    = '0;
    req1_valid   = 1'b0;
    req1_key     = '0;
    req1_flag    = '0;
    db_ready     = 1'b0;
    db_out_valid = 1'b0;
    db_out_flag  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_db_valid", db_valid, 0);
    chk("rst_db_key", db_key, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_stray", stray_cnt, 0);
    chk("rst_tmo", timeout_cnt, 0);

    // single port 0 lookup
    tick();
    db_ready   = 1'b1;
    req0_valid = 1'b1;
    req0_key   = 96'h0A000001_0A000002_1F900000;
    req0_flag  = 4'h1;
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_db_valid", db_valid, 1);
    chk("t1_db_key", db_key,
        96'h0A000001_0A000002_1F900000);
    repeat (5) tick();
    db_out_valid = 1'b1;
    db_out_flag  = 4'h3;
    tick();
    db_out_valid = 1'b0;
    db_out_flag  = 4'h0;
    @(negedge clk);
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_flag", rsp0_flag, 3);
    chk("t1_rsp1_valid", rsp1_valid, 0);

    // starvation: 8 x port 0 then 1 x port 1
    tick();
    req0_valid = 1'b1;
    req0_key   = 96'h0B000001_0B000002_00350000;
    req0_flag  = 4'h1;
    req1_valid = 1'b1;
    req1_key   = 96'hC0A80001_C0A80002_04D20000;
    req1_flag  = 4'h2;
    for (int i = 0; i < 18; i++) begin
      int w;
      serve(w);
      gseq[i] = w;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 18; i++)
      chk($sformatf("starve_g%0d", i), gseq[i],
          (i % 9 == 8) ? 1 : 0);

    // timeout with no DB reply
    tick();
    req0_valid = 1'b1;
    req0_key   = 96'h11111111_22222222_33330000;
    req0_flag  = 4'h1;
    @(negedge clk);
    chk("to_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("to_db_valid", db_valid, 1);
    repeat (15) tick();
    @(negedge clk);
    chk("to_early_rsp", rsp0_valid, 0);
    chk("to_early_cnt", timeout_cnt, 0);
    tick();
    req0_valid = 1'b1;
    req0_key   = 96'h44444444_55555555_66660000;
    req0_flag  = 4'h4;
    @(negedge clk);
    chk("to_rsp0_valid", rsp0_valid, 1);
    chk("to_rsp0_flag", rsp0_flag, 4'hF);
    chk("to_cnt", timeout_cnt, 1);
    chk("to_next_ready", req0_ready, 1);

    // race: reply on the expiry cycle
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("race_db_valid", db_valid, 1);
    repeat (15) tick();
    db_out_valid = 1'b1;
    db_out_flag  = 4'h2;
    tick();
    db_out_valid = 1'b0;
    db_out_flag  = 4'h0;
    @(negedge clk);
    chk("race_rsp0_valid", rsp0_valid, 1);
    chk("race_rsp0_flag", rsp0_flag, 2);
    chk("race_tmo_cnt", timeout_cnt, 1);

    // stray reply in IDLE
    tick();
    db_out_valid = 1'b1;
    db_out_flag  = 4'h1;
    tick();
    db_out_valid = 1'b0;
    db_out_flag  = 4'h0;
    @(negedge clk);
    chk("stray_cnt", stray_cnt, 1);
    chk("stray_rsp0", rsp0_valid, 0);
    chk("stray_rsp1", rsp1_valid, 0);

    // backpressure from the DB
    tick();
    db_ready   = 1'b0;
    req0_valid = 1'b1;
    req0_key   = 96'hDEADBEEF_CAFEF00D_12340000;
    req0_flag  = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", req0_ready, 0);
      chk("bp_db_valid", db_valid, 0);
      tick();
    end
    db_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_db_valid_on", db_valid, 1);
    chk("bp_db_key", db_key,
        96'hDEADBEEF_CAFEF00D_12340000);

    // reset while waiting, then a late reply
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_db_valid", db_valid, 0);
    chk("rw_db_key", db_key, 0);
    chk("rw_db_flag", db_flag, 0);
    chk("rw_rsp0", rsp0_valid, 0);
    chk("rw_rsp1", rsp1_valid, 0);
    chk("rw_stray", stray_cnt, 0);
    chk("rw_tmo", timeout_cnt, 0);
    tick();
    db_out_valid = 1'b1;
    db_out_flag  = 4'h3;
    tick();
    db_out_valid = 1'b0;
    db_out_flag  = 4'h0;
    @(negedge clk);
    chk("rw_late_stray", stray_cnt, 1);
    chk("rw_late_rsp0", rsp0_valid, 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/db_req_arbiter.md
Name: db_req_arbiter

Overview:
- Shares the single key-lookup port of the DB datapath (hash + db_cont) between two requesters:
  - port 0: packet-path lookup, high priority.
  - port 1: control-plane insert/update/delete.
- The DB accepts one operation at a time and answers with a one-cycle out_valid/out_flag pulse. This block issues at most one outstanding operation, tags its owner, and routes the reply back to that owner.
- Guarantees port 1 forward progress with a starvation limit and recovers from lost replies with a timeout.

Parameters:
- KEY_SIZE, 96, key width (src IP, dst IP, dst UDP port, reserved).
- FLAG_SIZE, 4, op/flag width.
- STARVE_MAX, 8, consecutive port-0 grants allowed while port 1 is pending before port 1 is forced (1..255).
- TIMEOUT, 1024, cycles to wait for a DB reply before aborting (2..65535).

Ports:
- clk  in  1  system clock (156.25 MHz domain).
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  port 0 request.
- req0_key  in  KEY_SIZE  port 0 key.
- req0_flag  in  FLAG_SIZE  port 0 op.
- req0_ready  out  1  port 0 accept.
- req1_valid, req1_key, req1_flag, req1_ready: same as port 0, for port 1.
- rsp0_valid  out  1  port 0 reply pulse.
- rsp0_flag  out  FLAG_SIZE  port 0 reply code.
- rsp1_valid, rsp1_flag: same as port 0, for port 1.
- db_valid  out  1  issue pulse to DB.
- db_key  out  KEY_SIZE  key to DB.
- db_flag  out  FLAG_SIZE  op to DB.
- db_ready  in  1  DB can accept.
- db_out_valid  in  1  DB reply pulse.
- db_out_flag  in  FLAG_SIZE  DB reply code.
- stray_cnt  out  16  count of replies received with no operation outstanding; saturates at 16'hFFFF.
- timeout_cnt  out  16  count of aborted operations; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs are 0.
  - State goes to IDLE; starvation counter and timer clear.
  - Any operation in flight is abandoned with no reply to its requester.
  - A DB reply arriving after reset is treated as stray.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant logic is combinational.
  - If db_ready=1 and a request is valid, exactly one reqN_ready is asserted in the same cycle. The handshake completes on valid&ready.
  - Grant rule: port 0 wins unless req1_valid=1 and starve_cnt==STARVE_MAX, in which case port 1 wins.
  - starve_cnt rules (saturating at STARVE_MAX):
    - increments on each port-0 grant while req1_valid=1.
    - clears on a port-1 grant.
    - clears in any cycle with req1_valid=0.
  - On accept: register key/flag into db_key/db_flag, record owner, go to ISSUE.
  - Both reqN_ready are 0 when db_ready=0 and in every non-IDLE state.
- ISSUE:
  - db_valid=1 for exactly one cycle.
  - timer loads 0.
  - Go to WAIT.
  - Accept-to-db_valid latency is 1 cycle.
- WAIT:
  - timer increments each cycle.
  - On db_out_valid=1: next cycle the owner's rspN_valid=1 for one cycle with rspN_flag=db_out_flag. Go to IDLE.
  - On timer==TIMEOUT-1 with db_out_valid=0: next cycle the owner's rspN_valid=1 with rspN_flag=4'hF (FLAG_TIMEOUT). timeout_cnt increments. Go to IDLE.
  - db_out_valid in the same cycle as expiry: the real reply wins; no timeout is counted.
- Reply latency is 1 cycle after db_out_valid. A new grant is possible in the same cycle the reply pulse is driven (IDLE re-entered).
- db_out_valid while in IDLE or ISSUE: dropped and stray_cnt increments. Exception: in ISSUE it is also dropped, since the DB cannot reply before issue.
- db_key/db_flag hold their value until the next accept.
- rspN_flag is 0 whenever rspN_valid=0.
- Counters saturate at 16'hFFFF; they do not wrap.

Decomposition:
- Shared package db_pkg:
  - FLAG_SIZE, KEY_SIZE.
  - Status codes SUSPECTION=1, ARREST=2, FILTERED=3, EXPIRED=4, FLAG_TIMEOUT=4'hF.
  - Owner ids PORT_PKT=0, PORT_CTL=1.
  - State encoding for IDLE/ISSUE/WAIT.
- One sub-module, db_arb_prio: combinational grant plus the starvation counter register.
  - Inputs: clk, rst_n, req0_valid, req1_valid, grant_en.
  - Outputs: gnt0, gnt1.
- FSM, timer and counters stay in db_req_arbiter.

Test Plan:
- Single port-0 lookup:
  - Stimulus: key 96'h0A000001_0A000002_1F900000, flag 1, db_ready=1.
  - Expect: req0_ready in the same cycle; db_valid exactly 1 cycle later with that key. With the DB replying flag 3 after 5 cycles, expect rsp0_valid/flag=3 one cycle later; rsp1_valid stays 0.
- Starvation:
  - Stimulus: both ports valid continuously, STARVE_MAX=8.
  - Expect: grant sequence of 8×port0 then 1×port1, repeating. Port-1 replies are routed only to rsp1.
- Timeout:
  - Stimulus: TIMEOUT=16, DB never replies.
  - Expect: rspN_valid with flag 4'hF exactly 16 cycles after db_valid; timeout_cnt=1; next request accepted.
- Race:
  - Stimulus: db_out_valid (flag 2) on the expiry cycle.
  - Expect: rsp flag=2; timeout_cnt unchanged.
- Stray and backpressure:
  - db_out_valid in IDLE -> stray_cnt=1, no rsp pulses.
  - db_ready=0 with req0 valid -> req0_ready=0 and no issue until db_ready=1.
- Reset mid-WAIT:
  - Stimulus: rst_n low 1 cycle during WAIT, then a late db_out_valid.
  - Expect: all outputs 0, no rsp pulse, stray_cnt=1 after reset.
